alarm_sequencer: RTL and testbench

- Control stage directly upstream of the sweeping-tone beep generator.
- Decides when the alarm rings: arms on an RTC match, rings until stop or timeout, and supports limited snoozes.
- Debounces the two user buttons.
- Output alarm_en gates the tone generator; the top level holds the tone generator in reset while alarm_en=0.

---
 rtl/alarm_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_alarm_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: debounces the snooze/stop buttons and runs the
// IDLE/RINGING/SNOOZE control FSM that gates the downstream tone generator.

module AlarmDebounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [19:0] CntLast = 20'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q;
  logic        sync2_q;
  logic        stable_q;
  logic        stable_d;
  logic        stableDly_q;
  logic        press_q;
  logic [19:0] cnt_q;
  logic [19:0] cnt_d;

  // Adopt the synced level only after it has disagreed with the stable level long enough.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  // Two-flop synchronizer, debounce state and a registered pulse on each stable press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      stable_q    <= 1'b0;
      cnt_q       <= '0;
      stableDly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      stableDly_q <= stable_q;
      press_q     <= stable_q & ~stableDly_q;
    end
  end

  assign press_o = press_q;

endmodule

module alarm_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
  parameter int unsigned SNOOZE_SEC       = 300,
  parameter int unsigned RING_TIMEOUT_SEC = 60,
  parameter int unsigned MAX_SNOOZE       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       arm,
  input  logic       alarm_hit,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic       alarm_en,
  output logic [1:0] state,
  output logic [1:0] snooze_cnt,
  output logic       missed
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } state_e;

  localparam logic [15:0] RingLast   = 16'(RING_TIMEOUT_SEC - 1);
  localparam logic [15:0] SnoozeLast = 16'(SNOOZE_SEC - 1);
  localparam logic [1:0]  MaxSnooze  = 2'(MAX_SNOOZE);

  state_e      state_q;
  state_e      state_d;
  logic [15:0] timer_q;
  logic [15:0] timer_d;
  logic [1:0]  snoozeCnt_q;
  logic [1:0]  snoozeCnt_d;
  logic        missed_q;
  logic        missed_d;
  logic        snoozePulse;
  logic        stopPulse;

  AlarmDebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uSnoozeBtn (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_snooze),
    .press_o (snoozePulse)
  );

  AlarmDebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uStopBtn (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_stop),
    .press_o (stopPulse)
  );

  // Next-state rules: disarm beats stop, stop beats snooze, snooze beats timeout.
  always_comb begin
    state_d     = state_q;
    snoozeCnt_d = snoozeCnt_q;
    missed_d    = missed_q;
    timer_d     = timer_q;
    if (!arm) begin
      state_d     = IDLE;
      snoozeCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (alarm_hit) begin
            state_d     = RINGING;
            snoozeCnt_d = '0;
            missed_d    = 1'b0;
          end
        end
        RINGING: begin
          if (stopPulse) begin
            state_d     = IDLE;
            snoozeCnt_d = '0;
          end else if (snoozePulse && (snoozeCnt_q < MaxSnooze)) begin
            state_d     = SNOOZE;
            snoozeCnt_d = snoozeCnt_q + 2'd1;
          end else if (tick_1hz && (timer_q == RingLast)) begin
            state_d     = IDLE;
            snoozeCnt_d = '0;
            missed_d    = 1'b1;
          end
        end
        SNOOZE: begin
          if (stopPulse) begin
            state_d     = IDLE;
            snoozeCnt_d = '0;
          end else if (tick_1hz && (timer_q == SnoozeLast)) begin
            state_d = RINGING;
          end
        end
        default: begin
          state_d     = IDLE;
          snoozeCnt_d = '0;
        end
      endcase
    end
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick_1hz && (state_q != IDLE)) begin
      timer_d = timer_q + 16'd1;
    end
  end

  // State, seconds timer, snooze count and sticky missed flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      snoozeCnt_q <= '0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      snoozeCnt_q <= snoozeCnt_d;
      missed_q    <= missed_d;
    end
  end

  assign state      = state_q;
  assign alarm_en   = (state_q == RINGING);
  assign snooze_cnt = snoozeCnt_q;
  assign missed     = missed_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Testbench for alarm_sequencer: directed scenarios plus a random soak,
// all compared against a sliding-window behavioural model.

module tb_alarm_sequencer;

  localparam int DEB  = 4;
  localparam int SNZ  = 3;
  localparam int RTO  = 5;
  localparam int MAXS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       arm = 1'b0;
  logic       alarm_hit = 1'b0;
  logic       btn_snooze = 1'b0;
  logic       btn_stop = 1'b0;
  logic       alarm_en;
  logic [1:0] state;
  logic [1:0] snooze_cnt;
  logic       missed;
  logic [5:0] dutVec;

  int checks = 0;
  int failures = 0;
  int cycCount = 0;

  int mState = 0;
  int mTimer = 0;
  int mSnooze = 0;
  bit mMissed = 1'b0;
  logic [DEB+1:0] histSnz = '0;
  logic [DEB+1:0] histStop = '0;
  bit stSnz = 1'b0;
  bit stStop = 1'b0;
  bit roseSnz = 1'b0;
  bit roseStop = 1'b0;
  bit pressSnz = 1'b0;
  bit pressStop = 1'b0;

  alarm_sequencer #(
    .DEBOUNCE_CYCLES  (DEB),
    .SNOOZE_SEC       (SNZ),
    .RING_TIMEOUT_SEC (RTO),
    .MAX_SNOOZE       (MAXS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .arm        (arm),
    .alarm_hit  (alarm_hit),
    .btn_snooze (btn_snooze),
    .btn_stop   (btn_stop),
    .alarm_en   (alarm_en),
    .state      (state),
    .snooze_cnt (snooze_cnt),
    .missed     (missed)
  );

  assign dutVec = {state, alarm_en, snooze_cnt, missed};

  always #5 clk = ~clk;

  // Expected {state, alarm_en, snooze_cnt, missed} from the model.
  function automatic logic [5:0] expVec();
    return {2'(mState), (mState == 1), 2'(mSnooze), mMissed};
  endfunction

  // Behavioural model advanced once per rising edge using the inputs sampled at that edge.
  task automatic model_edge();
    bit stopEv;
    bit snzEv;
    int prev;
    if (rst) begin
      mState = 0; mTimer = 0; mSnooze = 0; mMissed = 1'b0;
      histSnz = '0; histStop = '0; stSnz = 1'b0; stStop = 1'b0;
      roseSnz = 1'b0; roseStop = 1'b0; pressSnz = 1'b0; pressStop = 1'b0;
      return;
    end
    stopEv = pressStop;
    snzEv = pressSnz;
    pressStop = roseStop;
    pressSnz = roseSnz;
    histStop = {histStop[DEB:0], btn_stop};
    histSnz = {histSnz[DEB:0], btn_snooze};
    roseStop = 1'b0;
    roseSnz = 1'b0;
    if (histStop[DEB+1:2] == {DEB{~stStop}}) begin
      stStop = ~stStop;
      roseStop = stStop;
    end
    if (histSnz[DEB+1:2] == {DEB{~stSnz}}) begin
      stSnz = ~stSnz;
      roseSnz = stSnz;
    end
    prev = mState;
    if (!arm) begin
      mState = 0;
      mSnooze = 0;
    end else if (mState == 0) begin
      if (alarm_hit) begin
        mState = 1; mSnooze = 0; mMissed = 1'b0;
      end
    end else if (mState == 1) begin
      if (stopEv) begin
        mState = 0; mSnooze = 0;
      end else if (snzEv && mSnooze < MAXS) begin
        mState = 2; mSnooze = mSnooze + 1;
      end else if (tick_1hz && (mTimer + 1 == RTO)) begin
        mState = 0; mSnooze = 0; mMissed = 1'b1;
      end
    end else begin
      if (stopEv) begin
        mState = 0; mSnooze = 0;
      end else if (tick_1hz && (mTimer + 1 == SNZ)) begin
        mState = 1;
      end
    end
    if (mState != prev) mTimer = 0;
    else if (tick_1hz && mState != 0) mTimer = mTimer + 1;
  endtask

  // One clock cycle: tick every 10th cycle, then sample outputs 1 time unit after the edge.
  task automatic step();
    tick_1hz = (cycCount % 10 == 9);
    @(posedge clk);
    model_edge();
    cycCount++;
    #1;
  endtask

  task automatic run_until(input logic [1:0] target, input int budget, output bit reached);
    reached = 1'b0;
    for (int i = 0; i < budget && !reached; i++) begin
      step();
      if (state == target) reached = 1'b1;
    end
  endtask

  task automatic press(input bit snz, input bit stp, input int len, input int tail);
    btn_snooze = snz;
    btn_stop = stp;
    for (int i = 0; i < len; i++) step();
    btn_snooze = 1'b0;
    btn_stop = 1'b0;
    for (int i = 0; i < tail; i++) step();
  endtask

  task automatic ring();
    alarm_hit = 1'b1;
    step();
    alarm_hit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (dutVec !== 6'b000000) begin
      failures++;
      $display("[TB] FAIL reset_const: got %b want 000000", dutVec);
    end
    checks++;
    if (dutVec !== expVec()) begin
      failures++;
      $display("[TB] FAIL reset_model: got %b want %b", dutVec, expVec());
    end
  endtask

  task automatic test_arm();
    arm = 1'b1;
    ring();
    checks++;
    if (dutVec !== 6'b011000) begin
      failures++;
      $display("[TB] FAIL arm_ring: got %b want 011000", dutVec);
    end
    checks++;
    if (dutVec !== expVec()) begin
      failures++;
      $display("[TB] FAIL arm_model: got %b want %b", dutVec, expVec());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int startCyc;
    int ticks;
    startCyc = cycCount;
    run_until(2'b00, 200, ok);
    ticks = 0;
    for (int k = startCyc; k < cycCount; k++) if (k % 10 == 9) ticks++;
    checks++;
    if (!ok || ticks != RTO) begin
      failures++;
      $display("[TB] FAIL timeout_ticks: got reached=%0d ticks=%0d want reached=1 ticks=%0d", ok, ticks, RTO);
    end
    checks++;
    if (dutVec !== 6'b000001) begin
      failures++;
      $display("[TB] FAIL timeout_missed: got %b want 000001", dutVec);
    end
    ring();
    checks++;
    if (dutVec !== 6'b011000 || dutVec !== expVec()) begin
      failures++;
      $display("[TB] FAIL missed_clear: got %b want 011000 (model %b)", dutVec, expVec());
    end
  endtask

  task automatic test_snooze();
    bit ok;
    press(1'b1, 1'b0, 6, 10);
    checks++;
    if (dutVec !== 6'b100010 || dutVec !== expVec()) begin
      failures++;
      $display("[TB] FAIL snooze1: got %b want 100010 (model %b)", dutVec, expVec());
    end
    run_until(2'b01, 100, ok);
    checks++;
    if (!ok || dutVec !== 6'b011010) begin
      failures++;
      $display("[TB] FAIL snooze_rering: got %b reached=%0d want 011010", dutVec, ok);
    end
    press(1'b1, 1'b0, 6, 10);
    checks++;
    if (dutVec !== 6'b100100 || dutVec !== expVec()) begin
      failures++;
      $display("[TB] FAIL snooze2: got %b want 100100 (model %b)", dutVec, expVec());
    end
    run_until(2'b01, 100, ok);
    press(1'b1, 1'b0, 6, 10);
    checks++;
    if (!ok || dutVec !== 6'b011100) begin
      failures++;
      $display("[TB] FAIL snooze3_ignored: got %b reached=%0d want 011100", dutVec, ok);
    end
    run_until(2'b00, 200, ok);
    checks++;
    if (!ok || dutVec !== 6'b000001 || dutVec !== expVec()) begin
      failures++;
      $display("[TB] FAIL snooze_timeout: got %b reached=%0d want 000001", dutVec, ok);
    end
  endtask

  task automatic test_debounce();
    ring();
    press(1'b0, 1'b1, 3, 10);
    checks++;
    if (dutVec !== 6'b011000 || dutVec !== expVec()) begin
      failures++;
      $display("[TB] FAIL glitch_ignored: got %b want 011000 (model %b)", dutVec, expVec());
    end
    btn_stop = 1'b1;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("[TB] FAIL stop_early: got state=%b after 7 cycles want 01", state);
    end
    step();
    checks++;
    if (state !== 2'b00 || alarm_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stop_latency: got state=%b en=%b after 8 cycles want 00/0", state, alarm_en);
    end
    btn_stop = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (dutVec !== expVec()) begin
      failures++;
      $display("[TB] FAIL stop_model: got %b want %b", dutVec, expVec());
    end
  endtask

  task automatic test_priority();
    bit found;
    ring();
    press(1'b1, 1'b0, 6, 4);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mState == 2 && mTimer == SNZ - 1 && cycCount % 10 == 9) found = 1'b1;
      else step();
    end
    checks++;
    if (!found || state !== 2'b10) begin
      failures++;
      $display("[TB] FAIL prio_setup: got state=%b found=%0d want 10/1", state, found);
    end
    arm = 1'b0;
    step();
    checks++;
    if (state !== 2'b00 || alarm_en !== 1'b0 || snooze_cnt !== 2'b00) begin
      failures++;
      $display("[TB] FAIL prio_disarm: got state=%b en=%b snz=%b want 00/0/00", state, alarm_en, snooze_cnt);
    end
    arm = 1'b1;
    ring();
    press(1'b1, 1'b1, 6, 10);
    checks++;
    if (dutVec !== 6'b000000 || dutVec !== expVec()) begin
      failures++;
      $display("[TB] FAIL prio_stop_snooze: got %b want 000000 (model %b)", dutVec, expVec());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ring();
    press(1'b1, 1'b0, 6, 10);
    run_until(2'b01, 100, ok);
    checks++;
    if (!ok || dutVec !== 6'b011010) begin
      failures++;
      $display("[TB] FAIL midrst_setup: got %b reached=%0d want 011010", dutVec, ok);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (dutVec !== 6'b000000 || dutVec !== expVec()) begin
      failures++;
      $display("[TB] FAIL midrst: got %b want 000000 (model %b)", dutVec, expVec());
    end
  endtask

  task automatic test_random();
    int holdSnz;
    int holdStop;
    holdSnz = 0;
    holdStop = 0;
    for (int i = 0; i < 800; i++) begin
      arm = ($urandom_range(0, 59) != 0);
      alarm_hit = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 399) == 0);
      if (holdSnz == 0) begin
        btn_snooze = 1'($urandom_range(0, 1));
        holdSnz = int'($urandom_range(1, 12));
      end
      if (holdStop == 0) begin
        btn_stop = 1'($urandom_range(0, 1));
        holdStop = int'($urandom_range(1, 12));
      end
      holdSnz--;
      holdStop--;
      step();
      checks++;
      if (dutVec !== expVec()) begin
        failures++;
        if (failures < 20)
          $display("[TB] FAIL random_cycle%0d: got %b want %b", i, dutVec, expVec());
      end
    end
    rst = 1'b0;
    alarm_hit = 1'b0;
    btn_snooze = 1'b0;
    btn_stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arm();
    test_timeout();
    test_snooze();
    test_debounce();
    test_priority();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
